// File: rtl/dds_synth.sv
// dds_synth: time-multiplexed multi-voice DDS tone generator.
// Each sample tick issues all voices, one per cycle, through a shared
// waveform -> volume -> accumulate pipeline and strobes one mixed sample.
module dds_synth #(
    parameter int  CHANNELS = 4,
    parameter int  PHASE_W  = 32,
    parameter int  LUT_AW   = 6,
    parameter int  AMP_W    = 8,
    localparam int OUT_W    = AMP_W + $clog2(CHANNELS),
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               step_in,
    input  logic               cfg_we_in,
    input  logic [CH_W-1:0]    cfg_ch_in,
    input  logic [PHASE_W-1:0] cfg_incr_in,
    input  logic [1:0]         cfg_mode_in,
    input  logic [3:0]         cfg_vol_in,
    input  logic               cfg_en_in,
    output logic [OUT_W-1:0]   sample_out,
    output logic               sample_valid_out,
    output logic               busy_out
);

    localparam int CNT_W = $clog2(CHANNELS + 1);
    localparam int LUT_N = 2 ** LUT_AW;
    // Phase bits that any waveform looks at
    localparam int TOP_W = (LUT_AW > AMP_W + 1) ? LUT_AW : AMP_W + 1;
    localparam int FRAC  = 28;
    localparam longint PI_Q = 64'sd843314857; // round(pi * 2^28)

    localparam logic [AMP_W-1:0] MSB_BIT = AMP_W'(1) << (AMP_W - 1);
    localparam logic [AMP_W-1:0] SQ_POS  = MSB_BIT - AMP_W'(1); // +(M-1)
    localparam logic [AMP_W-1:0] SQ_NEG  = MSB_BIT + AMP_W'(1); // -(M-1)

    // Offset-binary sine table, round(M + (M-1)*sin(2*pi*i/N)), built at
    // elaboration with fixed-point Taylor series so no real math is needed.
    function automatic logic [LUT_N*AMP_W-1:0] gen_sine_lut();
        logic [LUT_N*AMP_W-1:0] lut;
        longint x, x2, term, s, v, ii, m;
        lut = '0;
        m   = longint'(1) << (AMP_W - 1);
        for (int i = 0; i < LUT_N; i++) begin
            // fold angle into [-pi, pi] so the series converges quickly
            ii = (2 * i > LUT_N) ? longint'(i - LUT_N) : longint'(i);
            x  = (2 * PI_Q * ii) / LUT_N;
            x2 = (x * x) >>> FRAC;
            term = x;
            s    = x;
            for (int n = 1; n < 10; n++) begin
                term = -((term * x2) >>> FRAC) / longint'((2 * n) * (2 * n + 1));
                s    = s + term;
            end
            v = (m << FRAC) + (m - 1) * s + (longint'(1) << (FRAC - 1));
            v = v >>> FRAC;
            lut[i*AMP_W +: AMP_W] = v[AMP_W-1:0];
        end
        return lut;
    endfunction

    localparam logic [LUT_N*AMP_W-1:0] SINE_LUT = gen_sine_lut();

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;
    logic   start;

    logic [CNT_W-1:0]   cnt_q;
    logic               issue_vld, issue_last;

    logic [PHASE_W-1:0] phase_q [CHANNELS];
    logic [PHASE_W-1:0] incr_q  [CHANNELS];
    logic [1:0]         mode_q  [CHANNELS];
    logic [3:0]         vol_q   [CHANNELS];
    logic [CHANNELS-1:0] en_q;

    logic [TOP_W-1:0]   iss_top;
    logic [1:0]         iss_mode;
    logic [3:0]         iss_vol;
    logic               iss_en;

    logic [LUT_AW-1:0]  sin_idx;
    logic [AMP_W:0]     tri_p;
    logic [AMP_W-1:0]   tri_t;
    logic [AMP_W-1:0]   w_d;

    logic [2:1]               vld_pipe_q, last_pipe_q;
    logic signed [AMP_W-1:0]  s1_w_q;
    logic [3:0]               s1_vol_q;
    logic signed [AMP_W+3:0]  prod;
    logic signed [AMP_W-1:0]  s_d, s2_s_q;
    logic signed [OUT_W-1:0]  acc_q, acc_sum, sample_q;
    logic                     valid_q;

    assign issue_vld  = (state_q == RUN) && (cnt_q < CNT_W'(CHANNELS));
    assign issue_last = issue_vld && (cnt_q == CNT_W'(CHANNELS - 1));

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state: ticks start a frame only from IDLE; frame ends on the strobe
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (step_in) begin
                start   = 1'b1;
                state_d = RUN;
            end
            RUN:  if (valid_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Issue counter: voice index being read this cycle
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)      cnt_q <= '0;
        else if (start)     cnt_q <= '0;
        else if (issue_vld) cnt_q <= cnt_q + 1'b1;
    end

    // Voice state: issue advances phase; a config write lands last so a
    // same-cycle disable overrides the phase step
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < CHANNELS; k++) begin
                phase_q[k] <= '0;
                incr_q[k]  <= '0;
                mode_q[k]  <= '0;
                vol_q[k]   <= '0;
                en_q[k]    <= 1'b0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (issue_vld && cnt_q == CNT_W'(k) && en_q[k])
                    phase_q[k] <= phase_q[k] + incr_q[k];
                if (cfg_we_in && cfg_ch_in == CH_W'(k)) begin
                    incr_q[k] <= cfg_incr_in;
                    mode_q[k] <= cfg_mode_in;
                    vol_q[k]  <= cfg_vol_in;
                    en_q[k]   <= cfg_en_in;
                    if (!cfg_en_in) phase_q[k] <= '0;
                end
            end
        end
    end

    // Select the issuing voice's pre-update settings
    always_comb begin
        iss_top  = '0;
        iss_mode = '0;
        iss_vol  = '0;
        iss_en   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                iss_top  = phase_q[k][PHASE_W-1 -: TOP_W];
                iss_mode = mode_q[k];
                iss_vol  = vol_q[k];
                iss_en   = en_q[k];
            end
        end
    end

    // Waveform generation; offset-binary values become signed by flipping MSB
    always_comb begin
        sin_idx = iss_top[TOP_W-1 -: LUT_AW];
        tri_p   = iss_top[TOP_W-1 -: AMP_W+1];
        tri_t   = tri_p[AMP_W] ? ~tri_p[AMP_W-1:0] : tri_p[AMP_W-1:0];
        case (iss_mode)
            2'd0:    w_d = SINE_LUT[sin_idx*AMP_W +: AMP_W] ^ MSB_BIT;
            2'd1:    w_d = iss_top[TOP_W-1] ? SQ_NEG : SQ_POS;
            2'd2:    w_d = iss_top[TOP_W-1 -: AMP_W] ^ MSB_BIT;
            default: w_d = tri_t ^ MSB_BIT;
        endcase
        if (!iss_en) w_d = '0;
    end

    // Volume scale: |w*vol| < 2^(AMP_W+3), so AMP_W+4 bits hold it exactly
    always_comb begin
        prod = (AMP_W+4)'(s1_w_q) * (AMP_W+4)'($signed({1'b0, s1_vol_q}));
        s_d  = AMP_W'(prod >>> 4);
    end

    assign acc_sum = acc_q + OUT_W'(s2_s_q);

    // Pipeline stages 1/2 with valid and last-voice markers shifting alongside
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            s1_w_q      <= '0;
            s1_vol_q    <= '0;
            s2_s_q      <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[1], issue_vld};
            last_pipe_q <= {last_pipe_q[1], issue_last};
            s1_w_q      <= w_d;
            s1_vol_q    <= iss_vol;
            s2_s_q      <= s_d;
        end
    end

    // Stage 3: mix accumulate; last voice publishes the sum and strobes
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= vld_pipe_q[2] && last_pipe_q[2];
            if (start)              acc_q <= '0;
            else if (vld_pipe_q[2]) acc_q <= acc_sum;
            if (vld_pipe_q[2] && last_pipe_q[2]) sample_q <= acc_sum;
        end
    end

    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
    assign busy_out         = (state_q == RUN);

endmodule

// File: tb/tb_dds_synth.sv
// Directed bench for dds_synth with a scoreboard of expected mixed samples.
module tb_dds_synth;

    localparam int C  = 4;
    localparam int OW = 10;

    logic          clk_in = 1'b0;
    logic          rst_n_in, step_in, cfg_we_in, cfg_en_in;
    logic [1:0]    cfg_ch_in, cfg_mode_in;
    logic [31:0]   cfg_incr_in;
    logic [3:0]    cfg_vol_in;
    logic [OW-1:0] sample_out;
    logic          sample_valid_out, busy_out;

    dds_synth dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .step_in          (step_in),
        .cfg_we_in        (cfg_we_in),
        .cfg_ch_in        (cfg_ch_in),
        .cfg_incr_in      (cfg_incr_in),
        .cfg_mode_in      (cfg_mode_in),
        .cfg_vol_in       (cfg_vol_in),
        .cfg_en_in        (cfg_en_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .busy_out         (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int    checks = 0;
    int    errors = 0;
    int    nstrobe = 0;
    string tag_s = "init";
    logic signed [63:0] exp_q[$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; any strobe there is scored
    task automatic cyc();
        @(negedge clk_in);
        if (sample_valid_out === 1'b1) begin
            nstrobe++;
            if (exp_q.size() == 0) chk({tag_s, "_unexpected_strobe"}, sample_valid_out, 0);
            else                   chk({tag_s, "_sample"}, $signed(sample_out), exp_q.pop_front());
        end
    endtask

    task automatic cfg_wr(input int ch, input logic [31:0] incr, input int mode, input int vol, input bit en);
        cfg_we_in   = 1'b1;
        cfg_ch_in   = 2'(ch);
        cfg_incr_in = incr;
        cfg_mode_in = 2'(mode);
        cfg_vol_in  = 4'(vol);
        cfg_en_in   = en;
        cyc();
        cfg_we_in   = 1'b0;
    endtask

    // One full frame: tick, check busy, latency of strobe, return to idle
    task automatic tick_frame(input logic signed [63:0] e, input string tag);
        int n, s0;
        tag_s = tag;
        exp_q.push_back(e);
        s0 = nstrobe;
        step_in = 1'b1;
        cyc();
        step_in = 1'b0;
        chk({tag, "_busy_start"}, busy_out, 1);
        n = 1;
        while (nstrobe == s0 && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_latency"}, n, C + 3);
        cyc();
        chk({tag, "_busy_end"}, busy_out, 0);
    endtask

    function automatic logic signed [63:0] sine_exp(input int i, input int vol);
        real v;
        int  lut, w;
        v   = 128.0 + 127.0 * $sin(2.0 * 3.141592653589793 * real'(i) / 64.0);
        lut = $rtoi(v + 0.5);
        w   = lut - 128;
        return 64'((w * vol) >>> 4);
    endfunction

    task automatic clear_all();
        for (int ch = 0; ch < C; ch++) cfg_wr(ch, 32'h0, 0, 0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst_n_in = 1'b0; step_in = 1'b0; cfg_we_in = 1'b0; cfg_ch_in = '0;
        cfg_incr_in = '0; cfg_mode_in = '0; cfg_vol_in = '0; cfg_en_in = 1'b0;
        tag_s = "reset";
        repeat (3) cyc();
        chk("reset_sample", $signed(sample_out), 0);
        chk("reset_valid", sample_valid_out, 0);
        chk("reset_busy", busy_out, 0);
        rst_n_in = 1'b1;
        cyc();

        tick_frame(0, "all_disabled");

        // single sine voice; 66 ticks cover a full period plus the repeat
        cfg_wr(0, 32'h0400_0000, 0, 15, 1'b1);
        for (int i = 0; i < 66; i++) tick_frame(sine_exp(i % 64, 15), "sine");
        clear_all();

        // square mix
        for (int ch = 0; ch < C; ch++) cfg_wr(ch, 32'h0, 1, 15, 1'b1);
        tick_frame(476, "square4");
        tick_frame(476, "square4b");
        cfg_wr(2, 32'h0, 1, 0, 1'b1);
        tick_frame(357, "square_vol0");
        cfg_wr(3, 32'h0, 1, 15, 1'b0);
        tick_frame(238, "square_dis3");
        clear_all();

        // saw at half-rate: wraps every second tick
        cfg_wr(0, 32'h8000_0000, 2, 15, 1'b1);
        tick_frame(-120, "saw0");
        tick_frame(0,    "saw1");
        tick_frame(-120, "saw2");
        tick_frame(0,    "saw3");
        cfg_wr(0, 32'h0, 0, 0, 1'b0);

        // triangle quarter steps, including a negative floor case
        cfg_wr(0, 32'h4000_0000, 3, 15, 1'b1);
        tick_frame(-120, "tri0");
        tick_frame(0,    "tri1");
        tick_frame(119,  "tri2");
        tick_frame(-1,   "tri3");
        tick_frame(-120, "tri4");
        clear_all();

        // overrun: extra ticks while busy are dropped; first idle cycle accepts
        for (int ch = 0; ch < C; ch++) cfg_wr(ch, 32'h0, 1, 15, 1'b1);
        tag_s = "overrun";
        exp_q.push_back(476);
        exp_q.push_back(476);
        s0 = nstrobe;
        for (int off = 0; off <= 2 * C + 8; off++) begin
            int o;
            step_in = (off == 0 || off == 2 || off == C + 3 || off == C + 4);
            cyc();
            o = off + 1;
            chk($sformatf("overrun_busy_%0d", o), busy_out,
                (o <= C + 3) || (o >= C + 5 && o <= 2 * C + 7));
            chk($sformatf("overrun_valid_%0d", o), sample_valid_out,
                (o == C + 3) || (o == 2 * C + 7));
        end
        step_in = 1'b0;
        chk("overrun_strobes", nstrobe - s0, 2);

        // mid-frame config: ch0 changed after issue, ch3 before issue
        tag_s = "midcfg";
        exp_q.push_back(357);
        s0 = nstrobe;
        step_in = 1'b1;
        cyc();                     // cycle t+1: ch0 issues
        step_in = 1'b0;
        cyc();                     // cycle t+2
        cfg_we_in = 1'b1; cfg_ch_in = 2'd0; cfg_incr_in = '0;
        cfg_mode_in = 2'd1; cfg_vol_in = 4'd0; cfg_en_in = 1'b1;
        cyc();                     // cycle t+3
        cfg_ch_in = 2'd3;
        cyc();                     // cycle t+4: ch3 issues with new vol
        cfg_we_in = 1'b0;
        for (int n = 0; n < 40 && nstrobe == s0; n++) cyc();
        chk("midcfg_strobe", nstrobe - s0, 1);
        cyc();
        tick_frame(238, "midcfg_next");

        // reset mid-frame: outputs clear at once and no strobe follows
        tag_s = "midreset";
        s0 = nstrobe;
        step_in = 1'b1;
        cyc();
        step_in = 1'b0;
        cyc();                     // cycle t+2
        rst_n_in = 1'b0;
        #1;
        chk("midreset_sample", $signed(sample_out), 0);
        chk("midreset_valid", sample_valid_out, 0);
        chk("midreset_busy", busy_out, 0);
        cyc();
        cyc();
        rst_n_in = 1'b1;
        repeat (C + 6) cyc();
        chk("midreset_no_strobe", nstrobe - s0, 0);
        tick_frame(0, "post_reset");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
